// File: rtl/decode_ctrl_if.sv
// Handshake and control-bundle bus of the registered decode stage.
// slave = the decode stage, master = whoever feeds instructions and consumes the bundle.
interface decode_ctrl_if #(
  parameter int PC_W     = 32,
  parameter int ALU_OP_W = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  logic [PC_W-1:0]     in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [PC_W-1:0]     out_pc;
  logic                reg_write;
  logic                mem_to_reg;
  logic                mem_write;
  logic                mem_read;
  logic                branch;
  logic                alu_src;
  logic [1:0]          alu_src_b;
  logic [1:0]          jump;
  logic [ALU_OP_W-1:0] alu_op;
  logic [2:0]          funct3_out;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [4:0]          rd;
  logic                illegal;
  logic                is_muldiv;

  modport slave (
    input  in_valid, instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, reg_write, mem_to_reg, mem_write,
           mem_read, branch, alu_src, alu_src_b, jump, alu_op, funct3_out,
           rs1, rs2, rd, illegal, is_muldiv
  );

  modport master (
    output in_valid, instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, reg_write, mem_to_reg, mem_write,
           mem_read, branch, alu_src, alu_src_b, jump, alu_op, funct3_out,
           rs1, rs2, rd, illegal, is_muldiv
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I decode-control stage with load-use interlock and illegal detection.
// Define DECODE_M_EXT_EN to decode the M extension (alu_op 17..24, is_muldiv).
module decode_ctrl_stage #(
  parameter int PC_W           = 32,
  parameter int ALU_OP_W       = 5,
  parameter int LOAD_USE_STALL = 1
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  decode_ctrl_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam bit         STALL_EN   = (LOAD_USE_STALL > 0);
  localparam logic [1:0] STALL_INIT = STALL_EN ? 2'(LOAD_USE_STALL - 1) : 2'd0;

  typedef enum logic {RUN, STALL} state_t;

  state_t      state, state_nxt;
  logic [1:0]  stall_cnt, stall_cnt_nxt;
  logic        last_is_load;
  logic [4:0]  last_rd;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1_f, rs2_f, rd_f;

  logic        dec_rw, dec_m2r, dec_mw, dec_mr, dec_br, dec_asrc, dec_ill;
  logic [1:0]  dec_asb, dec_jmp;
  logic [4:0]  dec_op;
`ifdef DECODE_M_EXT_EN
  logic        dec_md;
  logic        muldiv_q;
`endif

  logic        uses_rs1, uses_rs2, hazard, slot_free, accept, in_ready_c;

  logic                out_valid_q, rw_q, m2r_q, mw_q, mr_q, br_q, asrc_q, ill_q;
  logic [1:0]          asb_q, jmp_q;
  logic [ALU_OP_W-1:0] op_q;
  logic [PC_W-1:0]     pc_q;
  logic [2:0]          f3_q;
  logic [4:0]          rs1_q, rs2_q, rd_q;

  assign opcode = bus.instr[6:0];
  assign rd_f   = bus.instr[11:7];
  assign f3     = bus.instr[14:12];
  assign rs1_f  = bus.instr[19:15];
  assign rs2_f  = bus.instr[24:20];
  assign f7     = bus.instr[31:25];

  // Shared funct3 -> ALU op map for the base register and immediate forms
  function automatic logic [4:0] base_op(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  base_op = 5'd0;
      3'b001:  base_op = 5'd5;
      3'b010:  base_op = 5'd8;
      3'b011:  base_op = 5'd9;
      3'b100:  base_op = 5'd4;
      3'b101:  base_op = alt ? 5'd7 : 5'd6;
      3'b110:  base_op = 5'd3;
      default: base_op = 5'd2;
    endcase
  endfunction

  always_comb begin
    dec_rw   = 1'b0;
    dec_m2r  = 1'b0;
    dec_mw   = 1'b0;
    dec_mr   = 1'b0;
    dec_br   = 1'b0;
    dec_asrc = 1'b0;
    dec_asb  = 2'b00;
    dec_jmp  = 2'b00;
    dec_op   = 5'd0;
    dec_ill  = 1'b0;
`ifdef DECODE_M_EXT_EN
    dec_md   = 1'b0;
`endif
    case (opcode)
      OPC_LUI:   begin dec_rw = 1'b1; dec_asrc = 1'b1; dec_asb = 2'b10; dec_op = 5'd10; end
      OPC_AUIPC: begin dec_rw = 1'b1; dec_asrc = 1'b1; dec_asb = 2'b01; end
      OPC_JAL:   begin dec_rw = 1'b1; dec_jmp = 2'b01; end
      OPC_JALR: begin
        dec_rw   = 1'b1;
        dec_jmp  = 2'b10;
        dec_asrc = 1'b1;
        dec_ill  = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_br = 1'b1;
        case (f3)
          3'b000:  dec_op = 5'd11;
          3'b001:  dec_op = 5'd12;
          3'b100:  dec_op = 5'd13;
          3'b101:  dec_op = 5'd14;
          3'b110:  dec_op = 5'd15;
          3'b111:  dec_op = 5'd16;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_rw   = 1'b1;
        dec_m2r  = 1'b1;
        dec_mr   = 1'b1;
        dec_asrc = 1'b1;
        dec_ill  = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec_mw   = 1'b1;
        dec_asrc = 1'b1;
        dec_ill  = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        dec_rw   = 1'b1;
        dec_asrc = 1'b1;
        dec_op   = base_op(f3, bus.instr[30]);
        if (f3 == 3'b001)
          dec_ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          dec_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_OP: begin
        dec_rw = 1'b1;
        case (f7)
          7'b0000000: dec_op = base_op(f3, 1'b0);
          7'b0100000: begin
            dec_op  = base_op(f3, 1'b1);
            dec_ill = (f3 != 3'b000) && (f3 != 3'b101);
            if (f3 == 3'b000)
              dec_op = 5'd1;
          end
`ifdef DECODE_M_EXT_EN
          7'b0000001: begin
            dec_op = 5'd17 + {2'b00, f3};
            dec_md = 1'b1;
          end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Interlock only looks at the register fields the incoming opcode actually reads
  assign uses_rs1  = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign uses_rs2  = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  assign hazard    = STALL_EN && last_is_load && (last_rd != 5'd0) &&
                     ((uses_rs1 && rs1_f == last_rd) || (uses_rs2 && rs2_f == last_rd));
  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      stall_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    if (flush) begin
      state_nxt     = RUN;
      stall_cnt_nxt = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (bus.in_valid && hazard && slot_free) begin
            state_nxt     = STALL;
            stall_cnt_nxt = STALL_INIT;
          end
        end
        STALL: begin
          if (slot_free) begin
            if (stall_cnt == 2'd0)
              state_nxt = RUN;
            else
              stall_cnt_nxt = stall_cnt - 2'd1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    in_ready_c = slot_free && (state == RUN) && !hazard && !flush;
  end

  // Bundle register: every cycle that empties the slot without a new accept is a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      rw_q         <= 1'b0;
      m2r_q        <= 1'b0;
      mw_q         <= 1'b0;
      mr_q         <= 1'b0;
      br_q         <= 1'b0;
      asrc_q       <= 1'b0;
      asb_q        <= 2'b00;
      jmp_q        <= 2'b00;
      op_q         <= '0;
      ill_q        <= 1'b0;
      pc_q         <= '0;
      f3_q         <= 3'b000;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      rd_q         <= 5'd0;
      last_is_load <= 1'b0;
      last_rd      <= 5'd0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      last_is_load <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      rw_q         <= dec_rw && !dec_ill;
      m2r_q        <= dec_m2r;
      mw_q         <= dec_mw && !dec_ill;
      mr_q         <= dec_mr && !dec_ill;
      br_q         <= dec_br && !dec_ill;
      asrc_q       <= dec_asrc;
      asb_q        <= dec_asb;
      jmp_q        <= dec_ill ? 2'b00 : dec_jmp;
      op_q         <= ALU_OP_W'(dec_op);
      ill_q        <= dec_ill;
      pc_q         <= bus.in_pc;
      f3_q         <= f3;
      rs1_q        <= rs1_f;
      rs2_q        <= rs2_f;
      rd_q         <= rd_f;
      last_is_load <= dec_mr && !dec_ill;
      last_rd      <= rd_f;
    end else if (slot_free) begin
      out_valid_q  <= 1'b0;
      last_is_load <= 1'b0;
    end
  end

`ifdef DECODE_M_EXT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      muldiv_q <= 1'b0;
    else if (!flush && accept)
      muldiv_q <= dec_md && !dec_ill;
  end
  assign bus.is_muldiv = muldiv_q;
`else
  assign bus.is_muldiv = 1'b0;
`endif

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pc     = pc_q;
  assign bus.reg_write  = rw_q;
  assign bus.mem_to_reg = m2r_q;
  assign bus.mem_write  = mw_q;
  assign bus.mem_read   = mr_q;
  assign bus.branch     = br_q;
  assign bus.alu_src    = asrc_q;
  assign bus.alu_src_b  = asb_q;
  assign bus.jump       = jmp_q;
  assign bus.alu_op     = op_q;
  assign bus.illegal    = ill_q;
  assign bus.funct3_out = f3_q;
  assign bus.rs1        = rs1_q;
  assign bus.rs2        = rs2_q;
  assign bus.rd         = rd_q;

endmodule
